// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bus plus the side-band preload port.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 5
);

  logic              mem_req;
  logic              mem_wmem;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [WORD_W-1:0] init_data;
  logic              init_ready;

  modport master (
    output mem_req, mem_wmem, mem_addr, mem_wdata, init_we, init_addr, init_data,
    input  mem_rdata, mem_ready, mem_err, init_ready
  );

  modport slave (
    input  mem_req, mem_wmem, mem_addr, mem_wdata, init_we, init_addr, init_data,
    output mem_rdata, mem_ready, mem_err, init_ready
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: one synchronous write port, one asynchronous read port.
// Out-of-range addresses write nothing and read as zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: fixed wait states, one-cycle ready
// pulse, registered load data, and a preload port usable only when idle.
//
// state | meaning
// IDLE  | no access outstanding; accepts a request or a preload write
// WAIT  | access latched, counting down wait states
// RESP  | mem_ready high for one cycle; a store commits on leaving
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic  clk,
  input logic  reset,
  dmem_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wmem_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic              init_ready_d;
  logic              store_commit_d;
  logic              in_range_d;
  logic              arr_we_d;
  logic [ADDR_W-1:0] arr_waddr_d;
  logic [WORD_W-1:0] arr_wdata_d;
  logic [ADDR_W-1:0] arr_raddr_d;
  logic [WORD_W-1:0] arr_rdata;

  // Init writes only happen in IDLE, so they can never collide with a store commit.
  always_comb begin
    init_ready_d   = (state_q == IDLE) && !bus.mem_req && !reset;
    store_commit_d = (state_q == RESP) && wmem_q && !reset;
    arr_we_d       = store_commit_d || (bus.init_we && init_ready_d);
    arr_waddr_d    = store_commit_d ? addr_q  : bus.init_addr;
    arr_wdata_d    = store_commit_d ? wdata_q : bus.init_data;
    arr_raddr_d    = (state_q == IDLE) ? bus.mem_addr : addr_q;
    in_range_d     = int'(arr_raddr_d) < DEPTH;
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we_d),
    .waddr_i (arr_waddr_d),
    .wdata_i (arr_wdata_d),
    .raddr_i (arr_raddr_d),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.mem_req) begin
            addr_q  <= bus.mem_addr;
            wmem_q  <= bus.mem_wmem;
            wdata_q <= bus.mem_wdata;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end else begin
              // Zero wait states: the read address is still the live request address.
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= !in_range_d;
              rdata_q <= bus.mem_wmem ? '0 : arr_rdata;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= !in_range_d;
            rdata_q <= wmem_q ? '0 : arr_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_ready  = ready_q;
  assign bus.mem_err    = err_q;
  assign bus.init_ready = init_ready_d;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 wait states / 16 words, 0 wait states / 32 words)
// checked against a word-array reference model with expected response cycles.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic        req  [2];
  logic        wm   [2];
  logic [4:0]  addr [2];
  logic [31:0] wdat [2];
  logic        iwe  [2];
  logic [4:0]  iaddr[2];
  logic [31:0] idat [2];
  logic        rdy  [2];
  logic        err  [2];
  logic [31:0] rd   [2];
  logic        irdy [2];

  logic [31:0] model [2][32];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_if #(.ADDR_W(5)) bus0 ();
  dmem_if #(.ADDR_W(5)) bus1 ();

  dmem_responder #(.ADDR_W(5), .DEPTH(16), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.ADDR_W(5), .DEPTH(32), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  assign bus0.mem_req = req[0];   assign bus1.mem_req = req[1];
  assign bus0.mem_wmem = wm[0];   assign bus1.mem_wmem = wm[1];
  assign bus0.mem_addr = addr[0]; assign bus1.mem_addr = addr[1];
  assign bus0.mem_wdata = wdat[0]; assign bus1.mem_wdata = wdat[1];
  assign bus0.init_we = iwe[0];   assign bus1.init_we = iwe[1];
  assign bus0.init_addr = iaddr[0]; assign bus1.init_addr = iaddr[1];
  assign bus0.init_data = idat[0]; assign bus1.init_data = idat[1];
  assign rdy[0] = bus0.mem_ready; assign rdy[1] = bus1.mem_ready;
  assign err[0] = bus0.mem_err;   assign err[1] = bus1.mem_err;
  assign rd[0] = bus0.mem_rdata;  assign rd[1] = bus1.mem_rdata;
  assign irdy[0] = bus0.init_ready; assign irdy[1] = bus1.init_ready;

  function automatic int wcyc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int dep(int d);
    return (d == 0) ? 16 : 32;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic mon_one(int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    else if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ready dut%0d at cycle %0d: got ready=1, expected ready=0", d, cyc);
    end else begin
      chk($sformatf("rdata_dut%0d", d), rd[d], e.rdata);
      chk($sformatf("err_dut%0d", d), 32'(err[d]), 32'(e.err));
      chk($sformatf("ready_cycle_dut%0d", d), 32'(cyc), 32'(e.due));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rdy[0]) mon_one(0);
      if (rdy[1]) mon_one(1);
    end
  end

  // Callers sit just after a rising edge; this cycle becomes the accept cycle.
  task automatic start_req(int d, bit w, logic [4:0] a, logic [31:0] dat);
    exp_t e;
    req[d] = 1'b1; wm[d] = w; addr[d] = a; wdat[d] = dat;
    e.err   = (int'(a) >= dep(d));
    e.rdata = (w || e.err) ? 32'h0 : model[d][a];
    e.due   = cyc + wcyc(d) + 1;
    if (w && !e.err) model[d][a] = dat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_resp(int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rdy[d]) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d at cycle %0d: got no ready, expected ready", d, cyc);
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic issue(int d, bit w, logic [4:0] a, logic [31:0] dat);
    start_req(d, w, a, dat);
    wait_resp(d);
  endtask

  task automatic do_init(int d, logic [4:0] a, logic [31:0] dat, bit exp_rdy);
    iwe[d] = 1'b1; iaddr[d] = a; idat[d] = dat;
    @(negedge clk);
    chk($sformatf("init_ready_dut%0d", d), 32'(irdy[d]), 32'(exp_rdy));
    if (exp_rdy && int'(a) < dep(d)) model[d][a] = dat;
    @(posedge clk); #1;
    iwe[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wm[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
      iwe[d] = 1'b0; iaddr[d] = '0; idat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_dut%0d", d), 32'(rdy[d]), 32'h0);
      chk($sformatf("rst_err_dut%0d", d), 32'(err[d]), 32'h0);
      chk($sformatf("rst_rdata_dut%0d", d), rd[d], 32'h0);
      chk($sformatf("rst_init_ready_dut%0d", d), 32'(irdy[d]), 32'h1);
    end
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) do_init(d, 5'(a), $urandom, 1'b1);

    // Preloaded load, then store followed immediately by a load of the same word.
    do_init(0, 5'd3, 32'h12345678, 1'b1);
    issue(0, 1'b0, 5'd3, 32'h0);
    issue(0, 1'b1, 5'd7, 32'hDEADBEEF);
    issue(0, 1'b0, 5'd7, 32'h0);

    start = cyc;
    for (int i = 0; i < 10; i++) issue(1, 1'b0, 5'(i * 3), 32'h0);
    chk("b2b_10_loads_cycles", 32'(cyc - start), 32'd20);

    // Out-of-range load and store on the 16-word instance.
    issue(0, 1'b0, 5'd20, 32'h0);
    issue(0, 1'b1, 5'd20, 32'hA5A5A5A5);
    issue(0, 1'b0, 5'd4, 32'h0);

    // Store aborted by reset while waiting.
    do_init(0, 5'd5, 32'h1, 1'b1);
    req[0] = 1'b1; wm[0] = 1'b1; addr[0] = 5'd5; wdat[0] = 32'hFFFF0000;
    @(posedge clk); #1;
    reset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("init_ready_in_reset", 32'(irdy[0]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    issue(0, 1'b0, 5'd5, 32'h0);

    // Preload collides with a request and is dropped; retried when idle it lands.
    start_req(0, 1'b0, 5'd9, 32'h0);
    do_init(0, 5'd9, 32'hBAD0BAD0, 1'b0);
    wait_resp(0);
    do_init(0, 5'd9, 32'hC0FFEE00, 1'b1);
    issue(0, 1'b0, 5'd9, 32'h0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0)
          do_init(d, 5'($urandom_range(0, 31)), $urandom, 1'b1);
        else
          issue(d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("pending_dut0", 32'(q0.size()), 32'h0);
    chk("pending_dut1", 32'(q1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory slave at the far end of the CPU MEM-stage interface. It receives the MEM stage's read/write requests (word address from the ALU result, store data from the B operand) and returns load data after a configurable number of wait states. It drives a ready/stall handshake so the pipeline can freeze while an access is outstanding. A side-band init port preloads contents for test programs.

Parameters:
ADDR_W, 5, word-address width; matches the MEM-stage address slice
DEPTH, 32, number of 32-bit words implemented; must be <= 2**ADDR_W
WAIT_CYCLES, 2, wait states inserted between request acceptance and response; legal range 0..15

Ports:
Clock  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
mem_req  in  1  access request from the MEM stage; held high until mem_ready
mem_wmem  in  1  1 = store, 0 = load; held stable while mem_req=1
mem_addr  in  ADDR_W  word address; held stable while mem_req=1
mem_wdata  in  32  store data; held stable while mem_req=1
mem_rdata  out  32  load data; valid only in the cycle mem_ready=1
mem_ready  out  1  one-cycle completion pulse; pipeline stalls while mem_req=1 and mem_ready=0
mem_err  out  1  with mem_ready: address >= DEPTH
init_we  in  1  preload write strobe
init_addr  in  ADDR_W  preload word address
init_data  in  32  preload data
init_ready  out  1  high when a preload write will be accepted this cycle

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wait counter=0, mem_ready=0, mem_err=0, mem_rdata=0. Array contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE with mem_req=1: latch addr/wmem/wdata. Go to WAIT if WAIT_CYCLES>0 and load counter with WAIT_CYCLES-1. Otherwise go to RESP.
- WAIT: decrement the counter each cycle. Go to RESP in the cycle after the counter reads 0.
- RESP: mem_ready=1 for exactly one cycle, then IDLE.
  - Load: mem_rdata = array[latched addr], registered on entry to RESP.
  - Store: array[latched addr] is written on the RESP->IDLE edge. mem_rdata=0.
- Latency: mem_ready rises WAIT_CYCLES+1 cycles after the accepting edge. Minimum access is 2 cycles (WAIT_CYCLES=0).
- Back-to-back: a request still high in the IDLE cycle after RESP is a new access. A store followed immediately by a load to the same address returns the new data.
- Out of range (addr >= DEPTH): normal timing. Load returns 0, store is dropped, mem_err=1 alongside mem_ready.
- mem_req dropped before mem_ready (protocol violation): the access still completes and the ready pulse is still issued. The bench flags it.
- Reset mid-access (WAIT or RESP): return to IDLE. A pending store is not committed and no ready pulse is issued.
- Init port:
  - init_ready = (state==IDLE && mem_req==0 && !reset).
  - init_we with init_ready=1 writes init_data to init_addr on that edge. Out-of-range addresses are ignored.
  - init_we with init_ready=0 is dropped silently. A functional request always has priority.
- Outputs mem_rdata, mem_ready and mem_err are registered, with no combinational path from inputs.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum (IDLE/WAIT/RESP) and WORD_W=32.
  - Localparam for counter width, 4 bits.
- Sub-module dmem_array: DEPTH x 32 storage, one synchronous write port (muxed between functional store and init write) and one asynchronous read port.
- FSM, counter and request latches stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2; preload addr 3 = 0x12345678; load addr 3 -> mem_ready pulses exactly 3 cycles after acceptance, mem_rdata=0x12345678, mem_err=0.
- Store 0xDEADBEEF to addr 7, then back-to-back load addr 7 -> load returns 0xDEADBEEF; each access shows one ready pulse.
- WAIT_CYCLES=0 -> ready on the cycle after acceptance. 10 back-to-back loads take 20 cycles.
- DEPTH=16; load addr 20 -> mem_err=1, mem_rdata=0. Store to addr 20, then load addr 4 -> the old addr 4 value is unchanged.
- Store to addr 5 (old value 0x1), reset asserted in WAIT -> no ready pulse; a later load of addr 5 returns 0x1.
- init_we asserted while mem_req=1 -> init_ready=0 and the write is dropped; the same init_we in IDLE with no request -> written, and readback matches.
